// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the core and dmem_responder.
// The core drives requests as master; the responder returns read data and ready as slave.
interface dmem_responder_if;
    logic        mem_rd_req_i;
    logic [31:0] mem_rd_addr_i;
    logic [31:0] mem_rd_data_o;
    logic        mem_wr_req_i;
    logic [3:0]  mem_wr_sel_i;
    logic [31:0] mem_wr_addr_i;
    logic [31:0] mem_wr_data_i;
    logic        ready_o;

    modport slave (
        input  mem_rd_req_i,
        input  mem_rd_addr_i,
        input  mem_wr_req_i,
        input  mem_wr_sel_i,
        input  mem_wr_addr_i,
        input  mem_wr_data_i,
        output mem_rd_data_o,
        output ready_o
    );

    modport master (
        output mem_rd_req_i,
        output mem_rd_addr_i,
        output mem_wr_req_i,
        output mem_wr_sel_i,
        output mem_wr_addr_i,
        output mem_wr_data_i,
        input  mem_rd_data_o,
        input  ready_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: 1-cycle registered reads, byte-masked write-first writes,
// power-up clear, sticky out-of-range fault capture and access counters.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_CLEAR | zeroing one word per cycle from index 0; requests ignored
//   ST_IDLE  | ready; serving reads and writes until the next reset
module dmem_responder #(
    parameter int unsigned DEPTH        = 4096,
    parameter int unsigned AW           = 12,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus,
    output logic              err_o,
    output logic [31:0]       err_addr_o,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o
);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    localparam logic [32:0]   BYTE_SPAN   = 33'(DEPTH) * 33'd4;
    localparam logic [AW-1:0] LAST_IDX    = AW'(DEPTH - 1);
    localparam state_t        RESET_STATE = CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;

    logic [31:0] r_mem [DEPTH];

    state_t      r_state;
    state_t      w_state_next;
    logic        r_ready;
    logic        w_ready_next;
    logic        w_clr_en;
    logic [AW-1:0] r_clr_idx;

    logic [31:0] r_rd_data;
    logic        r_err;
    logic [31:0] r_err_addr;
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    logic [31:0]   w_rd_off;
    logic [31:0]   w_wr_off;
    logic          w_rd_in;
    logic          w_wr_in;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_wr_idx;
    logic          w_rd_go;
    logic          w_wr_go;
    logic          w_rd_ok;
    logic          w_wr_ok;
    logic          w_rd_bad;
    logic          w_wr_bad;
    logic [31:0]   w_rd_word;

    // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign w_rd_off = bus.mem_rd_addr_i - BASE_ADDR;
    assign w_wr_off = bus.mem_wr_addr_i - BASE_ADDR;
    assign w_rd_in  = ({1'b0, w_rd_off} < BYTE_SPAN);
    assign w_wr_in  = ({1'b0, w_wr_off} < BYTE_SPAN);
    assign w_rd_idx = w_rd_off[AW+1:2];
    assign w_wr_idx = w_wr_off[AW+1:2];

    assign w_rd_go  = r_ready & bus.mem_rd_req_i;
    assign w_wr_go  = r_ready & bus.mem_wr_req_i;
    assign w_rd_ok  = w_rd_go & w_rd_in;
    assign w_wr_ok  = w_wr_go & w_wr_in;
    assign w_rd_bad = w_rd_go & ~w_rd_in;
    assign w_wr_bad = w_wr_go & ~w_wr_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RESET_STATE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= w_ready_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready_next = 1'b0;
        w_clr_en     = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_en = 1'b1;
                if (r_clr_idx == LAST_IDX) begin
                    w_state_next = ST_IDLE;
                    w_ready_next = 1'b1;
                end
            end
            ST_IDLE: begin
                w_ready_next = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clr_idx <= '0;
        end else if (w_clr_en) begin
            r_clr_idx <= r_clr_idx + AW'(1);
        end
    end

    // Write-first: a same-word read sees the enabled lanes of this cycle's write.
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        if (w_wr_ok && (w_wr_idx == w_rd_idx)) begin
            for (int l = 0; l < 4; l++) begin
                if (bus.mem_wr_sel_i[l]) begin
                    w_rd_word[8*l +: 8] = bus.mem_wr_data_i[8*l +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_clr_en) begin
                r_mem[r_clr_idx] <= '0;
            end else if (w_wr_ok) begin
                for (int l = 0; l < 4; l++) begin
                    if (bus.mem_wr_sel_i[l]) begin
                        r_mem[w_wr_idx][8*l +: 8] <= bus.mem_wr_data_i[8*l +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data  <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
        end else begin
            if (w_rd_ok) begin
                r_rd_data <= w_rd_word;
                r_rd_cnt  <= r_rd_cnt + 32'd1;
            end else if (w_rd_bad) begin
                r_rd_data <= '0;
            end
            if (w_wr_ok) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            // Only the first fault is recorded; a write fault wins a same-cycle tie.
            if (!r_err && (w_rd_bad || w_wr_bad)) begin
                r_err      <= 1'b1;
                r_err_addr <= w_wr_bad ? bus.mem_wr_addr_i : bus.mem_rd_addr_i;
            end
        end
    end

    assign bus.mem_rd_data_o = r_rd_data;
    assign bus.ready_o       = r_ready;
    assign err_o             = r_err;
    assign err_addr_o        = r_err_addr;
    assign rd_cnt_o          = r_rd_cnt;
    assign wr_cnt_o          = r_wr_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder (DEPTH=16): directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a word-array model.
module tb_dmem_responder;
    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus();
    logic        err_o;
    logic [31:0] err_addr_o;
    logic [31:0] rd_cnt_o;
    logic [31:0] wr_cnt_o;

    dmem_responder #(
        .DEPTH(DEPTH),
        .AW(AW),
        .BASE_ADDR(BASE),
        .CLEAR_ON_RST(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err_o(err_o),
        .err_addr_o(err_addr_o),
        .rd_cnt_o(rd_cnt_o),
        .wr_cnt_o(wr_cnt_o)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: plain word array, cycles-since-release for readiness.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rd, m_ea, m_rc, m_wc, m_ro, m_wo;
    logic        m_err, m_ready;
    int          m_since;

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_rd = 0; m_err = 0; m_ea = 0; m_rc = 0; m_wc = 0;
            m_ready = 0; m_since = 0;
        end else if (!m_ready) begin
            m_since++;
            if (m_since == DEPTH) begin
                m_ready = 1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
            end
        end else begin
            m_ro = bus.mem_rd_addr_i - BASE;
            m_wo = bus.mem_wr_addr_i - BASE;
            if (bus.mem_wr_req_i) begin
                if (m_wo < 32'(DEPTH * 4)) begin
                    for (int l = 0; l < 4; l++)
                        if (bus.mem_wr_sel_i[l])
                            m_mem[int'(m_wo >> 2)][8*l +: 8] = bus.mem_wr_data_i[8*l +: 8];
                    m_wc = m_wc + 1;
                end else if (!m_err) begin
                    m_err = 1; m_ea = bus.mem_wr_addr_i;
                end
            end
            if (bus.mem_rd_req_i) begin
                if (m_ro < 32'(DEPTH * 4)) begin
                    m_rd = m_mem[int'(m_ro >> 2)];
                    m_rc = m_rc + 1;
                end else begin
                    m_rd = 0;
                    if (!m_err) begin
                        m_err = 1; m_ea = bus.mem_rd_addr_i;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("m_ready",    {31'b0, bus.ready_o}, {31'b0, m_ready});
            cmp("m_rd_data",  bus.mem_rd_data_o, m_rd);
            cmp("m_err",      {31'b0, err_o}, {31'b0, m_err});
            cmp("m_err_addr", err_addr_o, m_ea);
            cmp("m_rd_cnt",   rd_cnt_o, m_rc);
            cmp("m_wr_cnt",   wr_cnt_o, m_wc);
        end
    end

    task automatic drive(bit rr, logic [31:0] ra, bit wr, logic [3:0] sel,
                         logic [31:0] wa, logic [31:0] wd);
        bus.mem_rd_req_i  = rr;
        bus.mem_rd_addr_i = ra;
        bus.mem_wr_req_i  = wr;
        bus.mem_wr_sel_i  = sel;
        bus.mem_wr_addr_i = wa;
        bus.mem_wr_data_i = wd;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic rd(logic [31:0] a);
        drive(1'b1, a, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] sel);
        drive(1'b0, 32'h0, 1'b1, sel, a, d);
    endtask

    // Reset for 'hold' edges, release, count cycles until ready (bounded).
    // When inject is set, a write to 0x3C is presented during the clear.
    task automatic do_reset(int hold, bit inject, output int n);
        rst = 1'b0;
        repeat (hold) idle();
        rst = 1'b1;
        n = 0;
        while (!bus.ready_o && n < 64) begin
            if (inject && n == 2) wr(32'h3C, 32'hFFFF_FFFF, 4'hF);
            else                  idle();
            n++;
        end
        if (!bus.ready_o) cmp("ready_timeout", {31'b0, bus.ready_o}, 32'h1);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 29) == 0) return 32'($urandom_range(64, 300));
        return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
    endfunction

    initial begin
        int n;
        logic [31:0] ra, wa;
        bus.mem_rd_req_i = 0; bus.mem_rd_addr_i = 0; bus.mem_wr_req_i = 0;
        bus.mem_wr_sel_i = 0; bus.mem_wr_addr_i = 0; bus.mem_wr_data_i = 0;
        @(negedge clk);
        chk_en = 1'b1;
        cmp("reset_ready", {31'b0, bus.ready_o}, 32'h0);
        cmp("reset_rd_data", bus.mem_rd_data_o, 32'h0);
        cmp("reset_wr_cnt", wr_cnt_o, 32'h0);

        // Power-up clear, write during clear ignored
        do_reset(2, 1'b1, n);
        cmp("clear_len", 32'(n), 32'd16);
        rd(32'h3C);
        cmp("clear_rd_3c", bus.mem_rd_data_o, 32'h0);
        cmp("clear_wr_cnt", wr_cnt_o, 32'h0);

        // Byte-lane writes
        do_reset(2, 1'b0, n);
        wr(32'h8, 32'hAABB_CCDD, 4'b1111);
        wr(32'h8, 32'h1122_3344, 4'b0101);
        rd(32'h8);
        cmp("lane_rd", bus.mem_rd_data_o, 32'hAA22_CC44);
        cmp("lane_rd_cnt", rd_cnt_o, 32'd1);
        cmp("lane_wr_cnt", wr_cnt_o, 32'd2);

        // Same-word read/write forwarding
        wr(32'h4, 32'h1234_5678, 4'hF);
        drive(1'b1, 32'h4, 1'b1, 4'b1000, 32'h4, 32'hFFFF_FFFF);
        cmp("fwd_rd", bus.mem_rd_data_o, 32'hFF34_5678);
        idle();
        rd(32'h4);
        cmp("fwd_later", bus.mem_rd_data_o, 32'hFF34_5678);
        wr(32'h4, 32'h0, 4'b0000);
        cmp("sel0_wr_cnt", wr_cnt_o, 32'd5);
        rd(32'h4);
        cmp("sel0_keep", bus.mem_rd_data_o, 32'hFF34_5678);

        // Fault capture
        rd(32'h40);
        cmp("flt_rd_data", bus.mem_rd_data_o, 32'h0);
        cmp("flt_err", {31'b0, err_o}, 32'h1);
        cmp("flt_addr", err_addr_o, 32'h40);
        wr(32'h100, 32'hDEAD_BEEF, 4'hF);
        cmp("flt_addr_keep", err_addr_o, 32'h40);
        cmp("flt_rd_cnt", rd_cnt_o, 32'd4);
        cmp("flt_wr_cnt", wr_cnt_o, 32'd5);
        rd(32'h4);
        cmp("flt_mem", bus.mem_rd_data_o, 32'hFF34_5678);

        // Hold and latency
        do_reset(1, 1'b0, n);
        wr(32'h8, 32'hCAFE_F00D, 4'hF);
        wr(32'h0, 32'h0102_0304, 4'hF);
        rd(32'h8);
        cmp("lat_rd", bus.mem_rd_data_o, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            idle();
            cmp("lat_hold", bus.mem_rd_data_o, 32'hCAFE_F00D);
        end
        rd(32'h0);
        cmp("b2b_0", bus.mem_rd_data_o, 32'h0102_0304);
        rd(32'h8);
        cmp("b2b_8", bus.mem_rd_data_o, 32'hCAFE_F00D);

        // Both fault in one cycle: write address wins
        drive(1'b1, 32'h80, 1'b1, 4'hF, 32'h44, 32'h5555_5555);
        cmp("dual_flt_addr", err_addr_o, 32'h44);
        cmp("dual_flt_rd", bus.mem_rd_data_o, 32'h0);

        // Reset mid-clear at index 7
        rst = 1'b0;
        repeat (2) idle();
        rst = 1'b1;
        repeat (7) idle();
        rst = 1'b0;
        idle();
        cmp("mid_ready", {31'b0, bus.ready_o}, 32'h0);
        rst = 1'b1;
        n = 0;
        while (!bus.ready_o && n < 64) begin
            idle();
            n++;
        end
        cmp("mid_clear_len", 32'(n), 32'd16);
        cmp("mid_err", {31'b0, err_o}, 32'h0);
        cmp("mid_rd_cnt", rd_cnt_o, 32'h0);
        cmp("mid_wr_cnt", wr_cnt_o, 32'h0);

        // Randomized traffic, occasional resets
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) != 0);
            ra = rand_addr();
            wa = ($urandom_range(0, 3) == 0) ? ra : rand_addr();
            drive(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), wa, $urandom());
        end
        rst = 1'b1;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder sitting on the core's load/store port.
- Receives read requests from the decode stage and returns the word one cycle later, in time for execute.
- Receives byte-masked write requests from the execute stage.
- Adds power-up clear sequencing, same-word read/write forwarding, out-of-range fault capture and access counters for bring-up and debug.

Parameters:
- DEPTH, 4096, number of 32-bit words; power of two.
- AW, 12, word-index width, equal to log2(DEPTH).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; 4-byte aligned.
- CLEAR_ON_RST, 1, when 1, all words are zeroed after reset before the block becomes ready.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset (sampled on clk; 0 = reset).
- mem_rd_req_i  input  1  read request strobe.
- mem_rd_addr_i  input  32  read byte address.
- mem_rd_data_o  output  32  read data, registered.
- mem_wr_req_i  input  1  write request strobe.
- mem_wr_sel_i  input  4  byte enables; bit n writes byte lane n (bits 8n+7:8n).
- mem_wr_addr_i  input  32  write byte address.
- mem_wr_data_i  input  32  write data, already lane-aligned by the core.
- ready_o  output  1  1 when requests are accepted.
- err_o  output  1  sticky out-of-range fault flag.
- err_addr_o  output  32  byte address of the first fault.
- rd_cnt_o  output  32  count of accepted in-range reads.
- wr_cnt_o  output  32  count of accepted in-range writes.

Behaviour:
Reset (rst=0 at a clock edge):
- mem_rd_data_o=0, err_o=0, err_addr_o=0, rd_cnt_o=0, wr_cnt_o=0, ready_o=0.
- State goes to CLEAR if CLEAR_ON_RST=1, otherwise to IDLE.
- Asserting reset mid-clear restarts the clear from word 0.

State machine:
- CLEAR: internal index counter writes 0 to word idx, one word per cycle, starting at 0.
  - At idx=DEPTH-1 the next state is IDLE.
  - ready_o=0 throughout.
  - Requests in CLEAR are ignored: no write, no counter change, no fault; mem_rd_data_o holds 0.
- IDLE: ready_o=1; the block stays here until the next reset.
- A clear therefore takes exactly DEPTH cycles after reset deasserts. ready_o rises on the edge that completes word DEPTH-1.

Address decode:
- Offset = addr - BASE_ADDR, computed modulo 2^32.
- In-range iff offset < DEPTH*4. Word index = offset[AW+1:2]; offset[1:0] is ignored, so there is no misalignment fault.

Read:
- Request accepted in cycle N → mem_rd_data_o is valid after edge N+1 (1-cycle latency).
- With no request, mem_rd_data_o holds its last value.
- Out-of-range read returns 32'h0 and raises a fault.

Write:
- Applied at the edge of the cycle it is presented in.
- Only lanes with a set mem_wr_sel_i bit change. sel=4'b0000 is legal: no change, but wr_cnt_o still increments.
- Out-of-range write is dropped and raises a fault.

Same-cycle read and write to the same in-range word:
- The read returns the merged word: new bytes for enabled lanes, old bytes elsewhere.
- Memory is write-first; no stall.

Faults:
- err_o sets on the first out-of-range accepted request and stays set until reset.
- err_addr_o captures that first faulting address only.
- If the read and the write both fault in the same cycle, err_addr_o takes the write address.

Counters:
- rd_cnt_o and wr_cnt_o increment by 1 per accepted in-range request.
- Simultaneous read and write increment both.
- Each wraps from 32'hFFFF_FFFF to 0.

Test Plan:
- Reset with CLEAR_ON_RST=1, DEPTH=16: hold rst=0 for 2 cycles, release → ready_o=0 for exactly 16 cycles, then 1. Read address 0x3C → 32'h0. A write issued during clear leaves memory at 0 and wr_cnt_o=0.
- Byte-lane write: write 32'hAABBCCDD sel=4'b1111 to 0x8, then 32'h11223344 sel=4'b0101 to 0x8; read 0x8 → 32'hAA22CC44 one cycle after the request. rd_cnt_o=1, wr_cnt_o=2.
- Collision forwarding: word 0x4 holds 32'h12345678; in the same cycle read 0x4 and write 32'hFFFFFFFF sel=4'b1000 → next cycle mem_rd_data_o=32'hFF345678; a later read also returns 32'hFF345678.
- Fault capture: read 0x40 (DEPTH=16), then write 0x100 → mem_rd_data_o=0, err_o=1, err_addr_o=32'h40 (unchanged by the second fault), counters unchanged, memory unchanged.
- Hold and latency: read 0x8 in cycle N, then no request for 3 cycles → data appears after edge N+1 and holds through N+4. A back-to-back read of 0x0 then 0x8 returns each word on consecutive cycles.
- Reset mid-clear: assert rst=0 at clear index 7 → ready_o stays 0, and the clear restarts and completes DEPTH cycles after release. err_o and counters are 0.
